// File: rtl/lcd_scan_ctrl.sv
// lcd_scan_ctrl: pulls 1-bit pixels from the frame buffer and scans a 4-bit monochrome STN LCD.
// Optional build macro LCD_PATTERN_EN adds input pattern_sel, which replaces the captured pixel
// with a checkerboard while keeping the frame-buffer read cadence unchanged.
module lcd_scan_ctrl #(
   parameter int unsigned H_PIXELS = 320,
   parameter int unsigned V_LINES  = 240,
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned LP_WIDTH = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       enable,
   input  logic       pix_in,
`ifdef LCD_PATTERN_EN
   input  logic       pattern_sel,
`endif
   output logic       pix_rd,
   output logic       frame_sync,
   output logic       busy,
   output logic [3:0] lcd_data,
   output logic       lcd_cp,
   output logic       lcd_lp,
   output logic       lcd_flm,
   output logic       lcd_m
);

   localparam int unsigned LINE_TICKS = H_PIXELS + 4 + LP_WIDTH;
   localparam int unsigned LT_W       = $clog2(LINE_TICKS);
   localparam int unsigned LN_W       = (V_LINES > 1) ? $clog2(V_LINES) : 1;
   localparam int unsigned PS_W       = $clog2(CLK_DIV);

   localparam logic [LT_W-1:0] LT_SHIFT_LAST = LT_W'(H_PIXELS - 1);
   localparam logic [LT_W-1:0] LT_TAIL_LAST  = LT_W'(H_PIXELS + 3);
   localparam logic [LT_W-1:0] LT_LP_LAST    = LT_W'(LINE_TICKS - 1);
   localparam logic [LT_W-1:0] LT_LOAD_FIRST = LT_W'(4);
   localparam logic [LT_W-1:0] LT_LOAD_LAST  = LT_W'(H_PIXELS);
   localparam logic [LT_W-1:0] LT_CP_FIRST   = LT_W'(5);
   localparam logic [LT_W-1:0] LT_CP_LAST    = LT_W'(H_PIXELS + 2);
   localparam logic [LN_W-1:0] LN_LAST       = LN_W'(V_LINES - 1);
   localparam logic [PS_W-1:0] PS_LAST       = PS_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_TAIL   = 2'd2,
      ST_LPULSE = 2'd3
   } state_t;

   state_t            state_q,   state_d;
   logic [PS_W-1:0]   presc_q,   presc_d;
   logic [LT_W-1:0]   lt_q,      lt_d;       // tick index within the current line
   logic [LN_W-1:0]   line_q,    line_d;
   logic [3:0]        sr_q,      sr_d;
   logic [RD_LAT-1:0] rd_dly_q,  rd_dly_d;
   logic              pix_rd_q,  pix_rd_d;
   logic              fs_q,      fs_d;
   logic              busy_q,    busy_d;
   logic [3:0]        data_q,    data_d;
   logic              cp_q,      cp_d;
   logic              lp_q,      lp_d;
   logic              flm_q,     flm_d;
   logic              m_q,       m_d;
   logic              period_end_c;
   logic              tick_next_c;
   logic              cap_bit_c;

`ifdef LCD_PATTERN_EN
   logic              pat_sel_q, pat_sel_d;
   logic              pat_bit_q, pat_bit_d;
   logic [RD_LAT-1:0] pat_dly_q, pat_dly_d;
`endif

   // Last cycle of a tick period: state and tick index advance here.
   assign period_end_c = (state_q != ST_IDLE) && (presc_q == PS_LAST);

   // Next-state: scan sequencing, prescaler, line and frame counters.
   always_comb begin
      state_d = state_q;
      lt_d    = lt_q;
      line_d  = line_q;
      m_d     = m_q;
      presc_d = presc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_SHIFT;
               lt_d    = '0;
               line_d  = '0;
            end
         end
         ST_SHIFT: begin
            if (period_end_c) begin
               lt_d = lt_q + 1'b1;
               if (lt_q == LT_SHIFT_LAST) state_d = ST_TAIL;
            end
         end
         ST_TAIL: begin
            if (period_end_c) begin
               lt_d = lt_q + 1'b1;
               if (lt_q == LT_TAIL_LAST) state_d = ST_LPULSE;
            end
         end
         ST_LPULSE: begin
            if (period_end_c) begin
               if (lt_q == LT_LP_LAST) begin
                  lt_d = '0;
                  if (line_q == LN_LAST) begin
                     line_d  = '0;
                     m_d     = ~m_q;
                     state_d = enable ? ST_SHIFT : ST_IDLE;
                  end else begin
                     line_d  = line_q + 1'b1;
                     state_d = ST_SHIFT;
                  end
               end else begin
                  lt_d = lt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if ((state_d == ST_IDLE) || (state_q == ST_IDLE) || (presc_q == PS_LAST)) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   // The cycle after this one starts a tick period.
   assign tick_next_c = (state_d != ST_IDLE) && (presc_d == '0);

   // Pixel source for the shift register.
`ifdef LCD_PATTERN_EN
   assign cap_bit_c = pat_sel_q ? pat_dly_q[RD_LAT-1] : pix_in;
`else
   assign cap_bit_c = pix_in;
`endif

   // Read strobe delay line and MSB-first pixel shift register.
   always_comb begin
      rd_dly_d = RD_LAT'({rd_dly_q, pix_rd_q});
      sr_d     = sr_q;
      if (rd_dly_q[RD_LAT-1]) sr_d = {sr_q[2:0], cap_bit_c};
   end

`ifdef LCD_PATTERN_EN
   // Checkerboard bit follows the read strobe; selection latched at each line start.
   always_comb begin
      pat_bit_d = ~(lt_d[0] ^ line_d[0]);
      pat_dly_d = RD_LAT'({pat_dly_q, pat_bit_q});
      pat_sel_d = pat_sel_q;
      if ((state_d == ST_SHIFT) && (state_q != ST_SHIFT)) pat_sel_d = pattern_sel;
   end
`endif

   // Registered output values, updated on tick boundaries.
   always_comb begin
      pix_rd_d = tick_next_c && (state_d == ST_SHIFT);
      fs_d     = pix_rd_d && (lt_d == '0) && (line_d == '0);
      busy_d   = (state_d != ST_IDLE);
      data_d   = data_q;
      cp_d     = cp_q;
      lp_d     = lp_q;
      flm_d    = flm_q;
      if (state_d == ST_IDLE) begin
         data_d = '0;
         cp_d   = 1'b0;
         lp_d   = 1'b0;
         flm_d  = 1'b0;
      end else if (tick_next_c) begin
         lp_d  = (state_d == ST_LPULSE);
         flm_d = (state_d == ST_LPULSE) && (line_d == '0);
         cp_d  = (lt_d >= LT_CP_FIRST) && (lt_d <= LT_CP_LAST) && (lt_d[1] ^ lt_d[0]);
         if ((lt_d >= LT_LOAD_FIRST) && (lt_d <= LT_LOAD_LAST) && (lt_d[1:0] == 2'b00)) begin
            data_d = sr_d;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= ST_IDLE;
         presc_q  <= '0;
         lt_q     <= '0;
         line_q   <= '0;
         sr_q     <= '0;
         rd_dly_q <= '0;
         pix_rd_q <= 1'b0;
         fs_q     <= 1'b0;
         busy_q   <= 1'b0;
         data_q   <= '0;
         cp_q     <= 1'b0;
         lp_q     <= 1'b0;
         flm_q    <= 1'b0;
         m_q      <= 1'b0;
`ifdef LCD_PATTERN_EN
         pat_sel_q <= 1'b0;
         pat_bit_q <= 1'b0;
         pat_dly_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         lt_q     <= lt_d;
         line_q   <= line_d;
         sr_q     <= sr_d;
         rd_dly_q <= rd_dly_d;
         pix_rd_q <= pix_rd_d;
         fs_q     <= fs_d;
         busy_q   <= busy_d;
         data_q   <= data_d;
         cp_q     <= cp_d;
         lp_q     <= lp_d;
         flm_q    <= flm_d;
         m_q      <= m_d;
`ifdef LCD_PATTERN_EN
         pat_sel_q <= pat_sel_d;
         pat_bit_q <= pat_bit_d;
         pat_dly_q <= pat_dly_d;
`endif
      end
   end

   assign pix_rd     = pix_rd_q;
   assign frame_sync = fs_q;
   assign busy       = busy_q;
   assign lcd_data   = data_q;
   assign lcd_cp     = cp_q;
   assign lcd_lp     = lp_q;
   assign lcd_flm    = flm_q;
   assign lcd_m      = m_q;

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Directed bench for lcd_scan_ctrl with a small 8x3 panel and a 2-cycle-latency buffer model.
module tb_lcd_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       pix_in;
   logic       pix_rd, frame_sync, busy, lcd_cp, lcd_lp, lcd_flm, lcd_m;
   logic [3:0] lcd_data;
`ifdef LCD_PATTERN_EN
   logic       pattern_sel;
`endif

   lcd_scan_ctrl #(
      .H_PIXELS (8),
      .V_LINES  (3),
      .CLK_DIV  (4),
      .RD_LAT   (2),
      .LP_WIDTH (2)
   ) dut (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .enable      (en),
      .pix_in      (pix_in),
`ifdef LCD_PATTERN_EN
      .pattern_sel (pattern_sel),
`endif
      .pix_rd      (pix_rd),
      .frame_sync  (frame_sync),
      .busy        (busy),
      .lcd_data    (lcd_data),
      .lcd_cp      (lcd_cp),
      .lcd_lp      (lcd_lp),
      .lcd_flm     (lcd_flm),
      .lcd_m       (lcd_m)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // cycle counter
   int cyc = 0;
   always @(posedge clk) cyc++;

   // frame buffer model: pixel stream 1,0,1,1,0,0,1,0 per line, two-cycle read latency
   logic [7:0] stream = 8'b1011_0010;
   logic [2:0] bidx;
   logic       st1;
   always @(posedge clk) begin
      if (rst) begin
         bidx   <= '0;
         st1    <= 1'b0;
         pix_in <= 1'b0;
      end else begin
         st1    <= pix_rd ? stream[3'd7 - bidx] : 1'b0;
         if (pix_rd) bidx <= bidx + 3'd1;
         pix_in <= st1;
      end
   end

   // output monitor, sampled mid-cycle
   int n_rd = 0, rd_in_rst = 0, n_cp = 0, n_cp_hi = 0, n_lp = 0, n_flm = 0;
   int flm_bad = 0, fs_bad = 0, nib_bad = 0, setup_bad = 0, data_chg = 0;
   int fs_cyc[$], fs_rd[$], fs_m[$], lp_rise[$], nib[$];
   logic cp_prev = 1'b0, lp_prev = 1'b0;
   logic [3:0] data_prev = 4'h0;
   always @(negedge clk) begin
      if (pix_rd) n_rd++;
      if (rst && pix_rd) rd_in_rst++;
      if (frame_sync) begin
         fs_cyc.push_back(cyc);
         fs_rd.push_back(n_rd);
         fs_m.push_back(int'(lcd_m));
         if (!pix_rd) fs_bad++;
      end
      if (lcd_lp) n_lp++;
      if (lcd_lp && !lp_prev) lp_rise.push_back(cyc);
      if (lcd_flm) begin
         n_flm++;
         if (!lcd_lp) flm_bad++;
      end
      if (lcd_data != data_prev) data_chg = cyc;
      if (lcd_cp && !cp_prev) begin
         if (int'(lcd_data) != (((n_cp % 2) == 0) ? 11 : 2)) nib_bad++;
         if ((cyc - data_chg) != 4) setup_bad++;
         nib.push_back(int'(lcd_data));
         n_cp++;
      end
      if (lcd_cp) n_cp_hi++;
      cp_prev   = lcd_cp;
      lp_prev   = lcd_lp;
      data_prev = lcd_data;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_fs(input int n, input int budget, input string tag);
      int k = 0;
      while (fs_cyc.size() < n && k < budget) begin
         step(1);
         k++;
      end
      check(tag, int'(fs_cyc.size() >= n), 1);
   endtask

   task automatic check_quiet(input string tag, input int m_exp);
      check({tag, "_busy"},  int'(busy), 0);
      check({tag, "_rd"},    int'(pix_rd), 0);
      check({tag, "_fs"},    int'(frame_sync), 0);
      check({tag, "_data"},  int'(lcd_data), 0);
      check({tag, "_cp"},    int'(lcd_cp), 0);
      check({tag, "_lp"},    int'(lcd_lp), 0);
      check({tag, "_flm"},   int'(lcd_flm), 0);
      check({tag, "_m"},     int'(lcd_m), m_exp);
   endtask

   initial begin
      int k;
      int idle_cyc;
      int rd_base;
      int rd_snap;
      rst = 1'b1;
      en  = 1'b1;
`ifdef LCD_PATTERN_EN
      pattern_sel = 1'b0;
`endif
      // reset held with enable high
      step(3);
      check_quiet("rst", 0);
      check("rst_no_rd", rd_in_rst, 0);
      rst = 1'b0;

      // two complete frames
      wait_fs(3, 500, "frames_start");
      check("frame_period0", qget(fs_cyc, 1) - qget(fs_cyc, 0), 168);
      check("frame_period1", qget(fs_cyc, 2) - qget(fs_cyc, 1), 168);
      check("rd_per_frame",  qget(fs_rd, 1) - qget(fs_rd, 0), 24);
      check("rd_total",      n_rd, 49);
      check("line_period",   qget(lp_rise, 1) - qget(lp_rise, 0), 56);
      check("lp_offset",     qget(lp_rise, 0) - qget(fs_cyc, 0), 48);
      check("lp_cycles",     n_lp, 48);
      check("cp_pulses",     n_cp, 12);
      check("cp_hi_cycles",  n_cp_hi, 96);
      check("nib0",          qget(nib, 0), 11);
      check("nib1",          qget(nib, 1), 2);
      check("flm_cycles",    n_flm, 16);
      check("m_frame0",      qget(fs_m, 0), 0);
      check("m_frame1",      qget(fs_m, 1), 1);
      check("m_frame2",      qget(fs_m, 2), 0);

      // drop enable during line 1: frame completes, then idle
      step(70);
      en = 1'b0;
      k  = 0;
      while (busy && k < 300) begin
         step(1);
         k++;
      end
      idle_cyc = cyc;
      check("stop_timeout", int'(busy), 0);
      check("stop_at_boundary", idle_cyc - qget(fs_cyc, 2), 168);
      check("stop_frame_rd", n_rd - (qget(fs_rd, 2) - 1), 24);
      check_quiet("idle", 1);
      rd_snap = n_rd;
      step(40);
      check("idle_no_rd", n_rd - rd_snap, 0);
      check("idle_no_fs", fs_cyc.size(), 3);

      // restart, then reset pulse in line 1 SHIFT
      en = 1'b1;
      wait_fs(4, 20, "restart_fs");
      step(62);
      rst = 1'b1;
      step(1);
      check_quiet("midrst", 0);
      rst = 1'b0;
      step(1);
      check("rerun_fs", int'(frame_sync), 1);
      check("rerun_rd", int'(pix_rd), 1);
      check("rerun_busy", int'(busy), 1);
      wait_fs(6, 400, "rerun_frame");
      check("rerun_period", qget(fs_cyc, 5) - qget(fs_cyc, 4), 168);
      check("rerun_frame_rd", qget(fs_rd, 5) - qget(fs_rd, 4), 24);
      check("rerun_m", qget(fs_m, 5), 1);
      check("nib_seq", nib_bad, 0);
      check("data_setup", setup_bad, 0);
      check("flm_outside_lp", flm_bad, 0);
      check("fs_without_rd", fs_bad, 0);

`ifdef LCD_PATTERN_EN
      // checkerboard replaces the buffer pixel, read cadence unchanged
      pattern_sel = 1'b1;
      wait_fs(7, 200, "pat_fs");
      rd_base = qget(fs_rd, 6) - 1;
      k = nib.size();
      step(110);
      check("pat_nib_count", nib.size() - k, 4);
      check("pat_l0_g0", qget(nib, k),     10);
      check("pat_l0_g1", qget(nib, k + 1), 10);
      check("pat_l1_g0", qget(nib, k + 2), 5);
      check("pat_l1_g1", qget(nib, k + 3), 5);
      check("pat_rd", n_rd - rd_base, 16);
`else
      rd_base = 0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
